// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, divisor width default and data-bit counts.
// Kept separate so the receiver can adopt the same encoding later.
package uart_pkg;

    localparam int DIVW_DEFAULT = 24;
    localparam int NBITS8       = 8;
    localparam int NBITS9       = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BREAK = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter; zero flags the last clk of the current bit period.
// Holds at zero until reloaded, so one load per bit gives a period of load_val+1 clocks.
module uart_baud_cnt #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops words from a show-ahead FIFO and sends start, 8/9 data bits LSB first,
// then 1/2 stop bits. Also drives a line break on request. All outputs are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DIVW = DIVW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_n,
    input  logic [DIVW-1:0] ckdiv,
    input  logic            data9b,
    input  logic            stopb2,
    input  logic            brk,
    input  logic            tf_empty,
    input  logic [8:0]      tf_rbyte,
    output logic            tf_read,
    output logic            busy,
    output logic            tx_done,
    output logic            uart_txd
);

    tx_state_t       state;
    tx_state_t       state_nxt;

    logic [DIVW-1:0] div_lat;
    logic            data9b_lat;
    logic            stopb2_lat;
    logic [8:0]      shift;
    logic [3:0]      bit_cnt;
    logic            stop_cnt;

    logic            start_frame;
    logic            bit_end;
    logic            cnt_zero;
    logic            cnt_load;
    logic [DIVW-1:0] cnt_load_val;

    logic            txd_d;
    logic            busy_d;
    logic            done_d;
    logic            read_d;

    assign start_frame  = (state == ST_IDLE) && !brk && !tf_empty;
    assign bit_end      = cnt_zero && (state inside {ST_START, ST_DATA, ST_STOP});
    // The first bit of a frame uses ckdiv directly since div_lat is captured on that same edge.
    assign cnt_load_val = (state == ST_IDLE) ? ckdiv : div_lat;
    assign cnt_load     = start_frame || (bit_end && (state_nxt != ST_IDLE));

    uart_baud_cnt #(
        .W (DIVW)
    ) u_baud_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!clr_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (brk) begin
                    state_nxt = ST_BREAK;
                end else if (!tf_empty) begin
                    state_nxt = ST_START;
                end
            end
            ST_BREAK: begin
                if (!brk) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt == 4'd0)) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end && !stop_cnt) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; txd holds its level between bit boundaries.
    always_comb begin
        txd_d  = uart_txd;
        busy_d = busy;
        done_d = 1'b0;
        read_d = 1'b0;
        case (state)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (brk) begin
                    txd_d = 1'b0;
                end else if (!tf_empty) begin
                    txd_d  = 1'b0;
                    busy_d = 1'b1;
                    read_d = 1'b1;
                end
            end
            ST_BREAK: begin
                txd_d  = !brk;
                busy_d = 1'b0;
            end
            ST_START: begin
                if (bit_end) begin
                    txd_d = shift[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    txd_d = (bit_cnt == 4'd0) ? 1'b1 : shift[0];
                end
            end
            ST_STOP: begin
                if (bit_end && !stop_cnt) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_txd <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            tf_read  <= 1'b0;
        end else if (!clr_n) begin
            uart_txd <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            tf_read  <= 1'b0;
        end else begin
            uart_txd <= txd_d;
            busy     <= busy_d;
            tx_done  <= done_d;
            tf_read  <= read_d;
        end
    end

    // bit_cnt counts data bits still to follow the one currently on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            div_lat    <= '0;
            data9b_lat <= 1'b0;
            stopb2_lat <= 1'b0;
        end else if (!clr_n) begin
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else if (start_frame) begin
            shift      <= {tf_rbyte[8] & data9b, tf_rbyte[7:0]};
            div_lat    <= ckdiv;
            data9b_lat <= data9b;
            stopb2_lat <= stopb2;
        end else if (bit_end) begin
            case (state)
                ST_START: begin
                    shift   <= {1'b0, shift[8:1]};
                    bit_cnt <= data9b_lat ? 4'(NBITS9 - 1) : 4'(NBITS8 - 1);
                end
                ST_DATA: begin
                    if (bit_cnt == 4'd0) begin
                        stop_cnt <= stopb2_lat;
                    end else begin
                        shift   <= {1'b0, shift[8:1]};
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                ST_STOP: begin
                    stop_cnt <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a FIFO model feeds the DUT, each pushed word queues an expected
// frame record, and a line monitor pops records and checks every clk of each frame.
module tb_uart_tx;

    localparam int DIVW = 24;

    typedef struct {
        logic [8:0] word;
        int         div;
        bit         d9;
        bit         s2;
    } frame_t;

    logic            clk;
    logic            rst_n;
    logic            clr_n;
    logic [DIVW-1:0] ckdiv;
    logic            data9b;
    logic            stopb2;
    logic            brk;
    logic            tf_empty;
    logic [8:0]      tf_rbyte;
    logic            tf_read;
    logic            busy;
    logic            tx_done;
    logic            uart_txd;

    logic [8:0] fifo[$];
    frame_t     exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt  = 0;
    int n_read   = 0;
    int n_done   = 0;
    int t_done_prev = -1000;
    int last_len = 0;
    int last_gap = 0;
    bit clr_seen = 0;

    uart_tx #(.DIVW(DIVW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_n    (clr_n),
        .ckdiv    (ckdiv),
        .data9b   (data9b),
        .stopb2   (stopb2),
        .brk      (brk),
        .tf_empty (tf_empty),
        .tf_rbyte (tf_rbyte),
        .tf_read  (tf_read),
        .busy     (busy),
        .tx_done  (tx_done),
        .uart_txd (uart_txd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc_cnt);
        end
    endtask

    task automatic fifoRefresh();
        tf_empty = (fifo.size() == 0);
        tf_rbyte = tf_empty ? 9'h000 : fifo[0];
    endtask

    task automatic applyStimulus(input logic [8:0] word);
        frame_t rec;
        rec.word = word;
        rec.div  = int'(ckdiv);
        rec.d9   = data9b;
        rec.s2   = stopb2;
        fifo.push_back(word);
        exp_q.push_back(rec);
        fifoRefresh();
    endtask

    task automatic waitDone(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("tx_done reached", 32'(n_done >= target), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitBusy(input int budget);
        int k = 0;
        while (busy !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("frame started", 32'(busy), 1);
    endtask

    // Checks one frame cycle by cycle, starting at the first sample after the falling edge.
    task automatic checkFrame();
        frame_t rec;
        logic   ebit[12];
        int     nb, nbit, per, cyc, t_start, k;
        logic   o, bo, dn;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected frame", 1, 0);
            k = 0;
            while (busy === 1'b1 && k < 5000) begin
                @(negedge clk);
                k++;
            end
            return;
        end
        rec      = exp_q.pop_front();
        nb       = rec.d9 ? 9 : 8;
        nbit     = 1 + nb + (rec.s2 ? 2 : 1);
        per      = rec.div + 1;
        t_start  = cyc_cnt;
        last_gap = t_start - t_done_prev;
        ebit[0]  = 1'b0;
        for (int i = 0; i < nb; i++) ebit[1+i] = rec.word[i];
        for (int i = 1 + nb; i < 12; i++) ebit[i] = 1'b1;
        checkOutput("tf_read pulse", 32'(tf_read), 1);
        cyc = 0;
        for (int b = 0; b < nbit; b++) begin
            o  = ebit[b];
            bo = 1'b1;
            dn = 1'b0;
            for (int c = 0; c < per; c++) begin
                if (cyc > 0) @(negedge clk);
                if (clr_seen) begin
                    clr_seen = 0;
                    return;
                end
                if (uart_txd !== ebit[b]) o = uart_txd;
                if (busy !== 1'b1) bo = 1'b0;
                if (tx_done !== 1'b0) dn = 1'b1;
                if (cyc == 1) checkOutput("tf_read single", 32'(tf_read), 0);
                cyc++;
            end
            checkOutput($sformatf("txd bit%0d", b), 32'(o), 32'(ebit[b]));
            checkOutput("busy in frame", 32'(bo), 1);
            checkOutput("no early done", 32'(dn), 0);
        end
        @(negedge clk);
        checkOutput("tx_done at end", 32'(tx_done), 1);
        checkOutput("busy at end", 32'(busy), 0);
        checkOutput("txd after stop", 32'(uart_txd), 1);
        t_done_prev = cyc_cnt;
        last_len    = cyc_cnt - t_start;
        @(negedge clk);
        checkOutput("tx_done single", 32'(tx_done), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
        end
    end

    // FIFO pop model and pulse counters, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_done === 1'b1) n_done++;
            if (tf_read === 1'b1) begin
                n_read++;
                if (fifo.size() == 0) checkOutput("pop from empty fifo", 1, 0);
                else void'(fifo.pop_front());
                fifoRefresh();
            end
        end
    end

    initial begin
        @(negedge clk);
        forever begin
            if (rst_n === 1'b1 && clr_n === 1'b1 && busy === 1'b1 && uart_txd === 1'b0 && !clr_seen)
                checkFrame();
            else
                @(negedge clk);
        end
    end

    initial begin
        int base_r, base_d;
        logic bad;
        rst_n  = 1'b0;
        clr_n  = 1'b1;
        brk    = 1'b0;
        ckdiv  = 24'd9;
        data9b = 1'b0;
        stopb2 = 1'b0;
        fifoRefresh();
        #12;
        checkOutput("reset txd", 32'(uart_txd), 1);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset tf_read", 32'(tf_read), 0);
        checkOutput("reset tx_done", 32'(tx_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] 8N1 0xA5, ckdiv=9");
        base_r = n_read; base_d = n_done;
        applyStimulus(9'h0A5);
        waitDone(base_d + 1, 300);
        checkOutput("8N1 frame len", 32'(last_len), 100);
        checkOutput("8N1 reads", 32'(n_read - base_r), 1);
        checkOutput("8N1 dones", 32'(n_done - base_d), 1);

        $display("[TB] 8N1 bit 8 ignored");
        base_d = n_done;
        applyStimulus(9'h13C);
        waitDone(base_d + 1, 300);

        $display("[TB] 9N2 0x1FF, ckdiv=3, brk pulsed mid-frame");
        ckdiv = 24'd3; data9b = 1'b1; stopb2 = 1'b1;
        base_d = n_done;
        applyStimulus(9'h1FF);
        waitBusy(20);
        repeat (10) @(negedge clk);
        brk = 1'b1;
        repeat (5) @(negedge clk);
        brk = 1'b0;
        waitDone(base_d + 1, 200);
        checkOutput("9N2 frame len", 32'(last_len), 48);
        checkOutput("9N2 dones", 32'(n_done - base_d), 1);

        $display("[TB] back-to-back 0x55, 0x0F, ckdiv=0");
        ckdiv = 24'd0; data9b = 1'b0; stopb2 = 1'b0;
        base_r = n_read; base_d = n_done;
        applyStimulus(9'h055);
        applyStimulus(9'h00F);
        waitDone(base_d + 2, 200);
        checkOutput("b2b gap", 32'(last_gap), 1);
        checkOutput("b2b frame len", 32'(last_len), 10);
        checkOutput("b2b reads", 32'(n_read - base_r), 2);
        checkOutput("b2b dones", 32'(n_done - base_d), 2);

        $display("[TB] break for 50 clk with FIFO non-empty");
        ckdiv = 24'd2;
        base_r = n_read; base_d = n_done;
        brk = 1'b1;
        applyStimulus(9'h096);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        brk = 1'b0;
        checkOutput("break line low", 32'(bad), 0);
        checkOutput("break no read", 32'(n_read - base_r), 0);
        @(negedge clk);
        checkOutput("break release txd", 32'(uart_txd), 1);
        checkOutput("break release busy", 32'(busy), 0);
        @(negedge clk);
        checkOutput("post-break start", 32'({busy, uart_txd}), 32'b10);
        waitDone(base_d + 1, 200);

        $display("[TB] soft clear during data bit 3");
        ckdiv = 24'd9;
        base_d = n_done;
        applyStimulus(9'h03C);
        waitBusy(20);
        repeat (42) @(negedge clk);
        clr_n = 1'b0;
        clr_seen = 1;
        @(negedge clk);
        clr_n = 1'b1;
        checkOutput("clear txd", 32'(uart_txd), 1);
        checkOutput("clear busy", 32'(busy), 0);
        repeat (20) @(negedge clk);
        checkOutput("clear no done", 32'(n_done - base_d), 0);
        base_r = n_read;
        clr_n = 1'b0;
        applyStimulus(9'h0C3);
        repeat (5) @(negedge clk);
        checkOutput("no read in clear", 32'(n_read - base_r), 0);
        checkOutput("busy held in clear", 32'(busy), 0);
        clr_n = 1'b1;
        waitDone(base_d + 1, 300);
        checkOutput("post-clear frame len", 32'(last_len), 100);

        $display("[TB] ckdiv 9 -> 4 mid-frame");
        base_d = n_done;
        applyStimulus(9'h081);
        waitBusy(20);
        repeat (5) @(negedge clk);
        ckdiv = 24'd4;
        applyStimulus(9'h07E);
        waitDone(base_d + 2, 400);
        checkOutput("new ckdiv frame len", 32'(last_len), 50);
        checkOutput("ckdiv change dones", 32'(n_done - base_d), 2);

        checkOutput("scoreboard drained", 32'(exp_q.size()), 0);
        checkOutput("fifo drained", 32'(fifo.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
